// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues sequential fetches on a shared memory port
// and buffers returned words in a small FIFO that feeds the IF/ID stage.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        mem_grant,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_inst
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic          kill_q, kill_d;
  logic [31:0]   infl_pc_q;
  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW:0]   credits_used;

  assign mem_addr  = fetch_pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
  assign out_pc4   = out_valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'd0;
  assign out_inst  = out_valid ? inst_mem_q[rd_ptr_q] : 32'd0;

  // Credits count both buffered entries and the one response still on its way,
  // so a returning word always has a free slot.
  always_comb begin
    credits_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    mem_req      = !reset && !flush && (credits_used < CREDIT_MAX);
    issue        = mem_req && mem_grant;
    push         = inflight_q && !kill_q && !flush;
    pop          = out_valid && !stall && !flush;

    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;

    if (flush) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
      kill_d     = inflight_q;
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d    = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      inflight_d = issue;
      kill_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count/inflight alone.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= infl_pc_q;
      inst_mem_q[wr_ptr_q] <= mem_rdata;
    end
    if (issue) begin
      infl_pc_q <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_inst_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        mem_grant = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'd0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_pc, out_pc4, out_inst;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .redirect_pc(redirect_pc),
    .mem_grant(mem_grant), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .stall(stall), .out_valid(out_valid),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst)
  );

  // Reference: queue of buffered PCs, one pending fetch, next fetch address.
  logic [31:0] mq[$];
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = 32'd0;
  logic [31:0] m_fetch = RESET_PC;

  // Memory: answers the address it granted one cycle earlier.
  bit          rsp_v = 1'b0, rsp_nv = 1'b0;
  logic [31:0] rsp_addr = 32'd0, rsp_naddr = 32'd0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_check();
    bit          v;
    logic [31:0] hp;
    v  = (mq.size() != 0);
    hp = v ? mq[0] : 32'd0;
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_pc", out_pc, hp);
    chk("out_pc4", out_pc4, v ? hp + 32'd4 : 32'd0);
    chk("out_inst", out_inst, v ? word_of(hp) : 32'd0);
    chk("mem_req", 32'(mem_req), 32'(!flush && ((mq.size() + int'(m_pend)) < DEPTH)));
    chk("mem_addr", mem_addr, m_fetch);
  endtask

  task automatic drive(input bit f, input logic [31:0] rp, input bit g, input bit s);
    @(negedge clk);
    flush       = f;
    redirect_pc = rp;
    mem_grant   = g;
    stall       = s;
    mem_rdata   = rsp_v ? word_of(rsp_addr) : $urandom();
    #1;
    model_check();
    rsp_nv    = mem_req && mem_grant;
    rsp_naddr = mem_addr;
  endtask

  task automatic tick();
    int sz;
    bit req;
    @(posedge clk);
    rsp_v    = rsp_nv;
    rsp_addr = rsp_naddr;
    if (flush) begin
      mq.delete();
      m_pend  = 1'b0;
      m_fetch = redirect_pc;
    end else begin
      sz  = mq.size();
      req = (sz + int'(m_pend)) < DEPTH;
      if (sz != 0 && !stall) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_pend_pc);
      m_pend = req && mem_grant;
      if (m_pend) begin
        m_pend_pc = m_fetch;
        m_fetch   = m_fetch + 32'd4;
      end
    end
  endtask

  task automatic cyc(input bit f, input logic [31:0] rp, input bit g, input bit s);
    drive(f, rp, g, s);
    tick();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset     = 1'b1;
    flush     = 1'b0;
    mem_grant = 1'b0;
    stall     = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_pc4", out_pc4, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    mq.delete();
    m_pend  = 1'b0;
    m_fetch = RESET_PC;
    rsp_v   = 1'b0;
    rsp_nv  = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Streaming from reset: out_pc = RESET_PC + 4*(k-2) from the third cycle on.
  task automatic seq_from_reset(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      if (k == 0) chk("seq_first_addr", mem_addr, RESET_PC);
      if (k >= 2) begin
        chk("seq_pc", out_pc, RESET_PC + 32'(4 * (k - 2)));
        chk("seq_pc4", out_pc4, RESET_PC + 32'(4 * (k - 2) + 4));
      end else begin
        chk("seq_bubble", 32'(out_valid), 32'd0);
      end
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waits;
    bit found;

    repeat (2) @(posedge clk);
    apply_reset();

    seq_from_reset(10);

    // Stall for six cycles: head frozen at 0x20, queue fills, requests stop.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b1);
      chk("stall_head", out_pc, 32'h20);
      if (i == 5) chk("stall_full_req", 32'(mem_req), 32'd0);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      chk("stall_release_pc", out_pc, 32'h20 + 32'(4 * i));
      tick();
    end

    // Grant withheld: queue drains to a zero bubble.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b0);
      if (i == 5) begin
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_inst", out_inst, 32'd0);
        chk("drain_pc4", out_pc4, 32'd0);
      end
      tick();
    end

    // Flush to 0x40 with a fetch in flight.
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    chk("flush_no_req", 32'(mem_req), 32'd0);
    tick();
    waits = 0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      if (out_valid) begin
        found = 1'b1;
        chk("flush_target_pc", out_pc, 32'h40);
        chk("flush_latency", 32'(waits), 32'd2);
      end else begin
        waits++;
      end
      tick();
    end
    chk("flush_found", 32'(found), 32'd1);

    // Fill to three entries plus one in flight, then flush against pop and push.
    for (int i = 0; i < 10 && !(mq.size() == 3 && m_pend); i++) cyc(1'b0, 32'd0, 1'b1, 1'b1);
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    chk("flush_full_cleared", 32'(out_valid), 32'd0);
    tick();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      drive(1'b0, 32'd0, 1'b1, 1'b0);
      if (out_valid) begin
        found = 1'b1;
        chk("flush_full_pc", out_pc, 32'h100);
      end
      tick();
    end
    chk("flush_full_found", 32'(found), 32'd1);

    // Mid-stream reset with three buffered entries.
    for (int i = 0; i < 10 && mq.size() != 3; i++) cyc(1'b0, 32'd0, 1'b1, 1'b1);
    drive(1'b0, 32'd0, 1'b1, 1'b1);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    tick();
    apply_reset();
    seq_from_reset(6);

    // Randomized traffic, including wrap-around redirects.
    for (int i = 0; i < 3000; i++) begin
      bit          f, g, s;
      logic [31:0] rp;
      f  = ($urandom_range(0, 19) == 0);
      rp = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      g  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 3 : 7));
      cyc(f, rp, g, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
